// File: rtl/mealy_seq_det.sv
// Mealy serial pattern detector with elaboration-time transition table.
// Optional match counter enabled by MEALY_SEQ_DET_COUNT_EN.
module mealy_seq_det #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1001,
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic        in,
  input  logic        clk,
  input  logic        reset,
  output logic        out
`ifdef MEALY_SEQ_DET_COUNT_EN
  ,
  output logic [15:0] det_count
`endif
);

  localparam int SW = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;
  localparam logic [SW-1:0] S0    = '0;
  localparam logic [SW-1:0] SLAST = SW'(PATTERN_W - 1);

  // Longest pattern prefix that is a suffix of (prefix_k, b), capped
  // below a full match so a hit lands on the pattern's border.
  function automatic int nxt_fn(int k, bit b);
    int best;
    bit ok;
    int j;
    bit sb;
    best = 0;
    if (!OVERLAP && k == PATTERN_W - 1 && b == PATTERN[0])
      return 0;
    for (int l = 1; l <= k + 1; l++) begin
      if (l <= PATTERN_W - 1) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++) begin
          j  = k + 1 - l + i;
          sb = (j < k) ? PATTERN[PATTERN_W-1-j] : b;
          if (PATTERN[PATTERN_W-1-i] != sb)
            ok = 1'b0;
        end
        if (ok)
          best = l;
      end
    end
    return best;
  endfunction

  logic [2*PATTERN_W-1:0][SW-1:0] tbl;

  for (genvar k = 0; k < PATTERN_W; k++) begin : g_st
    for (genvar b = 0; b < 2; b++) begin : g_in
      assign tbl[2*k+b] = SW'(nxt_fn(k, 1'(b)));
    end
  end

  logic [SW-1:0] state;
  logic [SW-1:0] nxt;
  logic          legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S0;
    else
      state <= nxt;
  end

  always_comb begin
    legal = 1'b0;
    nxt   = S0;
    out   = 1'b0;
    for (int k = 0; k < PATTERN_W; k++)
      if (state == SW'(k))
        legal = 1'b1;
    if (legal)
      nxt = tbl[{state, in}];
    out = reset & (state == SLAST) & (in == PATTERN[0]);
  end

`ifdef MEALY_SEQ_DET_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      det_count <= '0;
    else if (out && det_count != 16'hFFFF)
      det_count <= det_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mealy_seq_det.sv
// Bench for mealy_seq_det: vector table, reset corners, random vs history model.
// Four instances: 1001/1001/1010/1010 with overlap 1/0/0/1.
module tb_mealy_seq_det;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in = 1'b0;
  logic [3:0] o;
`ifdef MEALY_SEQ_DET_COUNT_EN
  logic [15:0] dc [4];
`endif

  always #5 clk = ~clk;

  mealy_seq_det #(.PATTERN_W(4), .PATTERN(4'b1001), .OVERLAP(1'b1)) d0 (
    .in(in), .clk(clk), .reset(reset), .out(o[0])
`ifdef MEALY_SEQ_DET_COUNT_EN
    , .det_count(dc[0])
`endif
  );
  mealy_seq_det #(.PATTERN_W(4), .PATTERN(4'b1001), .OVERLAP(1'b0)) d1 (
    .in(in), .clk(clk), .reset(reset), .out(o[1])
`ifdef MEALY_SEQ_DET_COUNT_EN
    , .det_count(dc[1])
`endif
  );
  mealy_seq_det #(.PATTERN_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) d2 (
    .in(in), .clk(clk), .reset(reset), .out(o[2])
`ifdef MEALY_SEQ_DET_COUNT_EN
    , .det_count(dc[2])
`endif
  );
  mealy_seq_det #(.PATTERN_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) d3 (
    .in(in), .clk(clk), .reset(reset), .out(o[3])
`ifdef MEALY_SEQ_DET_COUNT_EN
    , .det_count(dc[3])
`endif
  );

  localparam bit [3:0] PAT [4] = '{4'b1001, 4'b1001, 4'b1010, 4'b1010};
  localparam bit       OVL [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  int n_cmp = 0;
  int n_bad = 0;
  bit hq [4][$];
  int cnt_m = 0;

  typedef struct {
    bit       rst_n;
    bit       b;
    bit [3:0] exp;
  } vec_t;

  vec_t vt [$];

  task automatic chk(string nm, logic [15:0] a, logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Hit when the bits seen since the last restart, plus the current bit,
  // end with the whole pattern.
  function automatic bit mdl_hit(int d, bit b);
    bit [3:0] cand;
    int n;
    if (!reset) return 1'b0;
    n = hq[d].size();
    if (n < 3) return 1'b0;
    cand = {hq[d][n-3], hq[d][n-2], hq[d][n-1], b};
    return cand == PAT[d];
  endfunction

  task automatic mdl_clear();
    for (int d = 0; d < 4; d++) hq[d].delete();
    cnt_m = 0;
  endtask

  task automatic mdl_edge();
    bit h;
    if (!reset) begin
      mdl_clear();
      return;
    end
    for (int d = 0; d < 4; d++) begin
      h = mdl_hit(d, in);
      if (d == 0 && h && cnt_m != 65535) cnt_m++;
      if (h && !OVL[d]) hq[d].delete();
      else begin
        hq[d].push_back(in);
        if (hq[d].size() > 3) void'(hq[d].pop_front());
      end
    end
  endtask

  task automatic drive(bit r, bit b);
    @(posedge clk);
    #1;
    reset = r;
    in = b;
    @(negedge clk);
  endtask

  task automatic check_all(string nm);
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s.d%0d", nm, d), 16'(o[d]), 16'(mdl_hit(d, in)));
`ifdef MEALY_SEQ_DET_COUNT_EN
    chk($sformatf("%s.cnt", nm), dc[0], 16'(cnt_m));
`endif
    mdl_edge();
  endtask

  initial begin
    vt = '{
      '{1'b0, 1'b1, 4'b0000}, '{1'b0, 1'b1, 4'b0000},
      '{1'b0, 1'b1, 4'b0000},
      '{1'b1, 1'b1, 4'b0000}, '{1'b1, 1'b0, 4'b0000},
      '{1'b1, 1'b0, 4'b0000}, '{1'b1, 1'b1, 4'b0011},
      '{1'b1, 1'b0, 4'b0000}, '{1'b1, 1'b0, 4'b0000},
      '{1'b1, 1'b1, 4'b0001},
      '{1'b0, 1'b0, 4'b0000},
      '{1'b1, 1'b1, 4'b0000}, '{1'b1, 1'b0, 4'b0000},
      '{1'b1, 1'b1, 4'b0000}, '{1'b1, 1'b0, 4'b1100},
      '{1'b1, 1'b1, 4'b0000}, '{1'b1, 1'b0, 4'b1000},
      '{1'b0, 1'b0, 4'b0000}
    };

    foreach (vt[i]) begin
      drive(vt[i].rst_n, vt[i].b);
      for (int d = 0; d < 4; d++)
        chk($sformatf("vec%0d.d%0d", i, d), 16'(o[d]), 16'(vt[i].exp[d]));
      mdl_edge();
    end

    drive(1'b1, 1'b1); check_all("pre1");
    drive(1'b1, 1'b0); check_all("pre2");
    drive(1'b1, 1'b0); check_all("pre3");
    @(posedge clk);
    #1 in = 1'b1;
    #1 chk("comb_hit", 16'(o[0]), 16'd1);
    #1 reset = 1'b0;
    #1 chk("rst_force", 16'(o[0]), 16'd0);
`ifdef MEALY_SEQ_DET_COUNT_EN
    chk("rst_cnt", dc[0], 16'd0);
`endif
    #1 reset = 1'b1;
    mdl_clear();
    #1 chk("discard0", 16'(o[0]), 16'd0);
    chk("discard1", 16'(o[1]), 16'd0);
    mdl_edge();
    drive(1'b1, 1'b0); check_all("post1");
    drive(1'b1, 1'b0); check_all("post2");
    drive(1'b1, 1'b1); check_all("post3");

`ifdef MEALY_SEQ_DET_COUNT_EN
    drive(1'b0, 1'b0); mdl_edge();
    for (int r = 0; r < 5; r++) begin
      drive(1'b1, 1'b1); check_all("c1");
      drive(1'b1, 1'b0); check_all("c0");
      drive(1'b1, 1'b0); check_all("c0");
      drive(1'b1, 1'b1); check_all("c1");
    end
    @(posedge clk);
    #1 in = 1'b0;
    chk("cnt5", dc[0], 16'd5);
    #1 reset = 1'b0;
    #1 chk("cnt_clr", dc[0], 16'd0);
    mdl_clear();
`endif

    drive(1'b0, 1'b0); mdl_edge();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) != 0, 1'($urandom));
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
